// File: rtl/switch_xfer_checker_pkg.sv
// Shared types and helpers for the switch transfer checker.
// Optional coverage counters are enabled with SWITCH_CHK_COVER_EN.
package switch_chk_pkg;

  localparam int CYC_W = 32;

  typedef enum logic [1:0] {
    DATA_MISMATCH = 2'd0,
    VALID_MISSING = 2'd1,
    ADDR_RANGE    = 2'd2,
    COLLISION     = 2'd3
  } err_kind_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_e;

  // Bit offset of a port's field inside a packed per-port bus.
  function automatic int port_slice(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/switch_xfer_checker_if.sv
// Shared switch datapath signals observed by the checker.
// The master side drives the switch signals; the checker only listens.
interface switch_xfer_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8
) ();

  logic [NUM_PORTS-1:0]        valid_in;
  logic [NUM_PORTS*DATA_W-1:0] data_in;
  logic [NUM_PORTS*ADDR_W-1:0] addr_in;
  logic [NUM_PORTS-1:0]        valid_out;
  logic [NUM_PORTS*DATA_W-1:0] data_out;

  modport master (output valid_in, data_in, addr_in, valid_out, data_out);
  modport slave  (input  valid_in, data_in, addr_in, valid_out, data_out);

endinterface

// File: rtl/switch_xfer_checker_delay_line.sv
// Per-port delay line aligning an input transfer with the switch output.
// LAT=0 is a pure pass-through.
module xfer_delay_line #(
  parameter int LAT    = 0,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic              chk_valid,
  output logic [ADDR_W-1:0] chk_addr,
  output logic [DATA_W-1:0] chk_data
);

  if (LAT == 0) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = clk ^ reset;
    assign chk_valid  = src_valid;
    assign chk_addr   = src_addr;
    assign chk_data   = src_data;
  end else begin : g_pipe
    logic [LAT-1:0]    vld_q;
    logic [ADDR_W-1:0] addr_q [LAT];
    logic [DATA_W-1:0] data_q [LAT];

    // Only the valid bits need reset; payload is ignored when not valid.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= src_valid;
        for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      addr_q[0] <= src_addr;
      data_q[0] <= src_data;
      for (int i = 1; i < LAT; i++) begin
        addr_q[i] <= addr_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end

    assign chk_valid = vld_q[LAT-1];
    assign chk_addr  = addr_q[LAT-1];
    assign chk_data  = data_q[LAT-1];
  end

endmodule

// File: rtl/switch_xfer_checker.sv
// On-line transfer checker for the N-port switch: error counters, sticky flags, first-error capture.
// Define SWITCH_CHK_COVER_EN to add the xfer_cnt / coll_seen coverage outputs.
module switch_xfer_checker
  import switch_chk_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int LAT       = 0,
  parameter int CNT_W     = 8,
  localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  switch_xfer_if.slave               bus,
  input  logic                       clr_err,
  output logic [NUM_PORTS-1:0]       err_sticky,
  output logic [NUM_PORTS*CNT_W-1:0] err_cnt,
  output logic                       first_err_vld,
  output logic [PORT_W-1:0]          first_err_port,
  output logic [1:0]                 first_err_kind,
  output logic [CYC_W-1:0]           first_err_cycle,
  output logic                       state
`ifdef SWITCH_CHK_COVER_EN
  ,
  output logic [NUM_PORTS*16-1:0]    xfer_cnt,
  output logic                       coll_seen
`endif
);

  logic [NUM_PORTS-1:0]       chk_vld;
  logic [ADDR_W-1:0]          chk_addr [NUM_PORTS];
  logic [DATA_W-1:0]          chk_data [NUM_PORTS];
  err_kind_e                  kind     [NUM_PORTS];
  logic [NUM_PORTS-1:0]       err_hit, coll_hit, sticky_d;
  logic [NUM_PORTS*CNT_W-1:0] cnt_d;
  logic [PORT_W-1:0]          first_port;
  err_kind_e                  first_kind, cap_kind;
  state_e                     state_q, state_d;
  logic                       cap_load;
  logic [CYC_W-1:0]           cyc_cnt;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dly
    xfer_delay_line #(.LAT(LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dly (
      .clk       (clk),
      .reset     (reset),
      .src_valid (bus.valid_in[p]),
      .src_addr  (bus.addr_in[port_slice(p, ADDR_W) +: ADDR_W]),
      .src_data  (bus.data_in[port_slice(p, DATA_W) +: DATA_W]),
      .chk_valid (chk_vld[p]),
      .chk_addr  (chk_addr[p]),
      .chk_data  (chk_data[p])
    );
  end

  // Classify each delayed transfer; earlier branches shadow later error kinds.
  always_comb begin
    err_hit  = '0;
    coll_hit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      kind[p] = DATA_MISMATCH;
      if (chk_vld[p]) begin
        if (32'(chk_addr[p]) >= 32'(NUM_PORTS)) begin
          err_hit[p] = 1'b1;
          kind[p]    = ADDR_RANGE;
        end else begin
          for (int q = 0; q < p; q++)
            if (chk_vld[q] && chk_addr[q] == chk_addr[p]) coll_hit[p] = 1'b1;
          if (coll_hit[p]) begin
            err_hit[p] = 1'b1;
            kind[p]    = COLLISION;
          end else begin
            for (int d = 0; d < NUM_PORTS; d++) begin
              if (chk_addr[p] == ADDR_W'(d)) begin
                if (!bus.valid_out[d]) begin
                  err_hit[p] = 1'b1;
                  kind[p]    = VALID_MISSING;
                end else if (bus.data_out[port_slice(d, DATA_W) +: DATA_W] != chk_data[p]) begin
                  err_hit[p] = 1'b1;
                  kind[p]    = DATA_MISMATCH;
                end
              end
            end
          end
        end
      end
    end
  end

  // Lowest erroring port wins the capture; scan downwards so it is assigned last.
  always_comb begin
    first_port = '0;
    first_kind = DATA_MISMATCH;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (err_hit[p]) begin
        first_port = PORT_W'(p);
        first_kind = kind[p];
      end
    end
  end

  // A clear in the same cycle as a new error still lets the error through.
  always_comb begin
    logic [CNT_W-1:0] cur;
    state_d  = state_q;
    cap_load = 1'b0;
    if (|err_hit) begin
      state_d  = S_FAULT;
      cap_load = (state_q == S_RUN) || clr_err;
    end else if (clr_err) begin
      state_d = S_RUN;
    end
    sticky_d = (clr_err ? '0 : err_sticky) | err_hit;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cur = clr_err ? '0 : err_cnt[p*CNT_W +: CNT_W];
      if (err_hit[p] && cur != '1) cur = cur + 1'b1;
      cnt_d[p*CNT_W +: CNT_W] = cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_RUN;
      cyc_cnt         <= '0;
      err_sticky      <= '0;
      err_cnt         <= '0;
      first_err_vld   <= 1'b0;
      first_err_port  <= '0;
      cap_kind        <= DATA_MISMATCH;
      first_err_cycle <= '0;
    end else begin
      state_q    <= state_d;
      cyc_cnt    <= cyc_cnt + 1'b1;
      err_sticky <= sticky_d;
      err_cnt    <= cnt_d;
      if (cap_load) begin
        first_err_vld   <= 1'b1;
        first_err_port  <= first_port;
        cap_kind        <= first_kind;
        first_err_cycle <= cyc_cnt;
      end else if (clr_err) begin
        first_err_vld   <= 1'b0;
        first_err_port  <= '0;
        cap_kind        <= DATA_MISMATCH;
        first_err_cycle <= '0;
      end
    end
  end

  assign first_err_kind = cap_kind;
  assign state          = state_q;

`ifdef SWITCH_CHK_COVER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt  <= '0;
      coll_seen <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        xfer_cnt[p*16 +: 16] <= (clr_err ? 16'd0 : xfer_cnt[p*16 +: 16]) + 16'(chk_vld[p]);
      coll_seen <= (coll_seen & ~clr_err) | (|coll_hit);
    end
  end
`endif

endmodule
